// File: rtl/deserializer.sv
// deserializer: MSB-first serial-to-parallel word assembler with a FWFT output FIFO.
module deserializer #(
    parameter int DATA_W     = 16,
    parameter int MOD_W      = $clog2(DATA_W),
    parameter int FIFO_DEPTH = 4,
    parameter int DROP_W     = 8
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic              ser_data_i,
    input  logic              ser_data_val_i,
    output logic [DATA_W-1:0] deser_data_o,
    output logic [MOD_W-1:0]  deser_mod_o,
    output logic              deser_data_val_o,
    input  logic              deser_ready_i,
    output logic              busy_o,
    output logic [DROP_W-1:0] drop_cnt_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = DATA_W + MOD_W;
    localparam logic [MOD_W-1:0] LAST = MOD_W'(DATA_W - 1);

    logic [DATA_W-1:0] shift, shift_n;
    logic [MOD_W-1:0]  cnt;
    logic [EW-1:0]     mem [FIFO_DEPTH];
    logic [AW:0]       wr_ptr, rd_ptr;
    logic [EW-1:0]     push_ent;
    logic              close_full, close_part, push, pop, full, empty, wr_en;

    // bit k lands directly at DATA_W-1-k so partial words come out left-aligned
    always_comb begin
        shift_n             = shift;
        shift_n[LAST - cnt] = ser_data_i;
        close_full          = ser_data_val_i && (cnt == LAST);
        close_part          = !ser_data_val_i && (cnt != '0);
        push                = close_full || close_part;
        push_ent            = {ser_data_val_i ? shift_n : shift, close_full ? MOD_W'(0) : cnt};
        empty               = wr_ptr == rd_ptr;
        full                = wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]};
        pop                 = !empty && deser_ready_i;
        wr_en               = push && (!full || pop);
    end

    // assembly register and bit counter; any close clears both
    always_ff @(posedge clk_i) begin
        if (srst_i || push) begin
            shift <= '0;
            cnt   <= '0;
        end else if (ser_data_val_i) begin
            shift <= shift_n;
            cnt   <= cnt + MOD_W'(1);
        end
    end

    // FIFO storage and pointers; a push into a full FIFO is accepted only alongside a pop
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr[AW-1:0]] <= push_ent;
                wr_ptr              <= wr_ptr + (AW+1)'(1);
            end
            if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // saturating count of words discarded because the FIFO was full
    always_ff @(posedge clk_i) begin
        if (srst_i) drop_cnt_o <= '0;
        else if (push && !wr_en && drop_cnt_o != '1) drop_cnt_o <= drop_cnt_o + DROP_W'(1);
    end

    assign {deser_data_o, deser_mod_o} = mem[rd_ptr[AW-1:0]];
    assign deser_data_val_o = !empty;
    assign busy_o           = cnt != '0;
endmodule

// File: tb/tb_deserializer.sv
// tb_deserializer: directed and random stimulus checked against a queue-based model.
module tb_deserializer;
    logic        clk = 0, srst = 1, din = 0, val = 0, rdy = 0;
    logic [15:0] dout;
    logic [3:0]  mod;
    logic        dval, busy;
    logic [7:0]  drop;
    int          checks = 0, errors = 0;

    typedef struct { logic [15:0] d; logic [3:0] m; } ent_t;
    logic m_bits[$];
    ent_t m_q[$];
    int   m_drop = 0;

    deserializer dut (
        .clk_i(clk), .srst_i(srst), .ser_data_i(din), .ser_data_val_i(val),
        .deser_data_o(dout), .deser_mod_o(mod), .deser_data_val_o(dval),
        .deser_ready_i(rdy), .busy_o(busy), .drop_cnt_o(drop)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic ent_t make_word();
        ent_t e;
        e.d = '0;
        foreach (m_bits[k]) e.d[15-k] = m_bits[k];
        e.m = (m_bits.size() == 16) ? 4'd0 : 4'(m_bits.size());
        return e;
    endfunction

    task automatic model_edge(input logic v, input logic d, input logic r, input logic s);
        ent_t e;
        bit   have = 0, pop;
        if (s) begin
            m_bits.delete(); m_q.delete(); m_drop = 0;
            return;
        end
        pop = (m_q.size() > 0) && r;
        if (v) begin
            m_bits.push_back(d);
            if (m_bits.size() == 16) begin e = make_word(); have = 1; m_bits.delete(); end
        end else if (m_bits.size() > 0) begin
            e = make_word(); have = 1; m_bits.delete();
        end
        if (pop) void'(m_q.pop_front());
        if (have) begin
            if (m_q.size() < 4) m_q.push_back(e);
            else if (m_drop < 255) m_drop++;
        end
    endtask

    task automatic compare();
        chk("data_val", dval, m_q.size() > 0);
        if (m_q.size() > 0) begin
            chk("data", dout, m_q[0].d);
            chk("mod", mod, m_q[0].m);
        end
        chk("busy", busy, m_bits.size() > 0);
        chk("drop_cnt", drop, m_drop);
    endtask

    task automatic step(input logic v, input logic d, input logic r, input logic s = 0);
        srst = s; val = v; din = d; rdy = r;
        @(posedge clk);
        model_edge(v, d, r, s);
        #1 compare();
    endtask

    task automatic send_word(input logic [15:0] w, input int n, input logic r);
        for (int k = 0; k < n; k++) step(1, w[15-k], r);
    endtask

    task automatic idle(input int n, input logic r);
        for (int k = 0; k < n; k++) step(0, 0, r);
    endtask

    logic [15:0] seq [6] = '{16'hA5C3, 16'h1234, 16'hFFFF, 16'h0F0F, 16'hAAAA, 16'h5555};
    logic [15:0] w5;
    int          d0;

    initial begin
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        chk("rst_data", dout, 16'h0);
        chk("rst_mod", mod, 4'h0);
        chk("rst_val", dval, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_drop", drop, 8'h0);

        // single full word, visible right after the 16th bit
        send_word(16'hA5C3, 15, 1);
        chk("t1_not_yet", dval, 1'b0);
        send_word(16'h8000 >> 15 & {15'b0, 1'b1} ? 16'hFFFF : 16'h0000, 0, 1);
        step(1, 1'b1, 1);
        chk("t1_val", dval, 1'b1);
        chk("t1_data", dout, 16'hA5C3);
        chk("t1_mod", mod, 4'd0);
        idle(2, 1);

        // partial word closed by valid dropping
        w5 = 16'hB000;
        send_word(w5, 5, 1);
        chk("t2_busy", busy, 1'b1);
        step(0, 0, 1);
        chk("t2_data", dout, 16'hB000);
        chk("t2_mod", mod, 4'd5);
        chk("t2_busy_low", busy, 1'b0);
        idle(2, 1);

        // back-to-back full words
        for (int i = 0; i < 3; i++) send_word(seq[i], 16, 1);
        idle(3, 1);

        // backpressure: six words into a four-deep queue
        for (int i = 0; i < 6; i++) send_word(seq[i], 16, 0);
        idle(3, 0);
        chk("t4_drop", drop, 8'd2);
        chk("t4_head", dout, 16'hA5C3);
        for (int i = 0; i < 4; i++) begin
            chk("t4_order", dout, seq[i]);
            step(0, 0, 1);
        end
        chk("t4_empty", dval, 1'b0);

        // full FIFO: close a word on the same edge as a pop
        for (int i = 0; i < 4; i++) send_word(seq[i], 16, 0);
        d0 = m_drop;
        send_word(16'hC0DE, 15, 0);
        step(1, 1'b0, 1);
        chk("t5_drop_same", drop, 8'(d0));
        chk("t5_head", dout, 16'h1234);
        idle(5, 1);
        chk("t5_drained", dval, 1'b0);

        // reset mid-word
        send_word(16'hFFFF, 7, 1);
        step(1, 1, 1, 1);
        chk("t6_busy", busy, 1'b0);
        chk("t6_val", dval, 1'b0);
        idle(2, 1);
        chk("t6_no_word", dval, 1'b0);
        send_word(16'h3C5A, 16, 0);
        chk("t6_data", dout, 16'h3C5A);
        idle(2, 1);

        // random traffic
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 9) < 8, 1'($urandom), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 999) == 0);
        idle(8, 1);

        // drop counter saturation
        step(0, 0, 0, 1);
        for (int i = 0; i < 262; i++) send_word(16'($urandom), 16, 0);
        chk("sat_drop", drop, 8'hFF);
        idle(6, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
